// File: rtl/aria_pkg.sv
// aria_pkg: shared ARIA mode/rotation constants, key-index type, NK and rotate helpers
package aria_pkg;
  localparam int KIDX_W = 5;
  typedef logic [KIDX_W-1:0] kidx_t;
  localparam logic [1:0] ARIA_128 = 2'b00;
  localparam logic [1:0] ARIA_192 = 2'b01;
  localparam logic [1:0] ARIA_256 = 2'b10;
  localparam int unsigned ROT_19 = 19;
  localparam int unsigned ROT_31 = 31;
  localparam int unsigned ROT_61 = 61;
  localparam logic [0:15][15:0] A_MASK = {
    16'h6358, 16'h93A4, 16'h9C52, 16'h6CA1,
    16'hC925, 16'hC61A, 16'h3685, 16'h394A,
    16'hA493, 16'h5863, 16'hA16C, 16'h529C,
    16'h1AC6, 16'h25C9, 16'h4A39, 16'h8536
  };
  function automatic kidx_t aria_nk(input logic [1:0] mode);
    return mode == ARIA_192 ? kidx_t'(15) : mode == ARIA_256 ? kidx_t'(17) : kidx_t'(13);
  endfunction
  function automatic logic [127:0] rotr(input logic [127:0] x, input int unsigned n);
    logic [255:0] t;
    t = {x, x} >> n;
    return t[127:0];
  endfunction
  function automatic int unsigned grp_rot(input logic [2:0] g);
    return g == 3'd0 ? ROT_19 : g == 3'd1 ? ROT_31 : g == 3'd2 ? 128 - ROT_61 :
           g == 3'd3 ? 128 - ROT_31 : 128 - ROT_19;
  endfunction
endpackage

// File: rtl/aria_diffusion_layer.sv
// aria_diffusion_layer: combinational ARIA A layer (involutive 16x16 binary byte matrix)
module aria_diffusion_layer
  import aria_pkg::*;
(
  input  logic [127:0] din,
  output logic [127:0] dout
);
  always_comb begin
    dout = '0;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        if (A_MASK[i][j]) dout[127-8*i -: 8] = dout[127-8*i -: 8] ^ din[127-8*j -: 8];
  end
endmodule

// File: rtl/aria_round_key_gen.sv
// aria_round_key_gen: captures W0..W3 and streams ARIA round keys over valid/ready; ARIA_RKEY_DEC_EN enables decryption order
module aria_round_key_gen
  import aria_pkg::*;
#(
  parameter int IDX_W = 5
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       aria_mode,
  input  logic             dec,
  input  logic [127:0]     w0,
  input  logic [127:0]     w1,
  input  logic [127:0]     w2,
  input  logic [127:0]     w3,
  output logic             busy,
  output logic             rkey_valid,
  input  logic             rkey_ready,
  output logic [127:0]     rkey,
  output logic [IDX_W-1:0] rkey_idx,
  output logic             rkey_last
);
  typedef enum logic {IDLE, EMIT} state_t;
  state_t state_q, state_d;
  logic [3:0][127:0] w_q, w_d;
  logic [1:0] mode_q, mode_d;
  logic dec_q, dec_d, dec_in;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [127:0] rkey_q, rkey_d, ek, a_out;
  logic last_q, last_d, capture, load, hs, use_a;
  kidx_t nk_d, pos, e, em;
`ifdef ARIA_RKEY_DEC_EN
  assign dec_in = dec;
  aria_diffusion_layer u_diff (.din(ek), .dout(a_out));
`else
  logic unused_dec;
  assign unused_dec = dec;
  assign dec_in = 1'b0;
  assign a_out = ek;
`endif
  assign hs = state_q == EMIT && rkey_ready;
  always_comb begin
    capture = state_q == IDLE && start;
    load = capture || (hs && !last_q);
    w_d = capture ? {w3, w2, w1, w0} : w_q;
    mode_d = capture ? aria_mode : mode_q;
    dec_d = capture ? dec_in : dec_q;
    state_d = capture ? EMIT : (hs && last_q) ? IDLE : state_q;
    idx_d = capture ? IDX_W'(1) : load ? idx_q + 1'b1 : idx_q;
  end
  always_comb begin
    nk_d = aria_nk(mode_d);
    pos = kidx_t'(idx_d);
    e = dec_d ? nk_d + kidx_t'(1) - pos : pos;
    em = e - kidx_t'(1);
    ek = w_d[em[1:0]] ^ rotr(w_d[em[1:0] + 2'd1], grp_rot(em[4:2]));
    use_a = dec_d && pos != kidx_t'(1) && pos != nk_d;
  end
  always_comb begin
    rkey_d = load ? (use_a ? a_out : ek) : rkey_q;
    last_d = load ? pos == nk_d : !hs && last_q;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q <= IDLE;
      w_q <= '0;
      mode_q <= '0;
      dec_q <= 1'b0;
      idx_q <= '0;
      rkey_q <= '0;
      last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q <= w_d;
      mode_q <= mode_d;
      dec_q <= dec_d;
      idx_q <= idx_d;
      rkey_q <= rkey_d;
      last_q <= last_d;
    end
  assign busy = state_q == EMIT;
  assign rkey_valid = state_q == EMIT;
  assign rkey = rkey_q;
  assign rkey_idx = idx_q;
  assign rkey_last = last_q;
endmodule
